// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// The burst-hold states are only used when RR_ARB_HOLD_EN is defined.
package rr_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // Increment an index, wrapping to 0 at n.
    function automatic int unsigned rot_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rot_prio_pick.sv
// Combinational rotating-priority picker: scans req upward from ptr, modulo
// NUM_REQ, and reports the first set bit as one-hot, index and valid.
module rot_prio_pick
    import rr_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    int unsigned      scan;
    logic [IDX_W-1:0] scan_idx;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        valid    = 1'b0;
        scan     = 32'(ptr);
        scan_idx = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDX_W'(scan);
            if (!valid && req[scan_idx]) begin
                gnt[scan_idx] = 1'b1;
                idx           = scan_idx;
                valid         = 1'b1;
            end
            scan = rot_next(scan, NUM_REQ);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with a registered rotating priority pointer.
// Define RR_ARB_HOLD_EN to let a winner keep the grant for up to MAX_HOLD cycles.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  MAX_HOLD = 4,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic [IDX_W-1:0]   ptr
);

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("rr_arbiter: NUM_REQ must be >= 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("rr_arbiter: MAX_HOLD must be >= 1");
    end

    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    logic [NUM_REQ-1:0] sel_gnt;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic               new_grant;

    rot_prio_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .ptr   (ptr_q),
        .req   (req),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef RR_ARB_HOLD_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [IDX_W-1:0] holder_q;
    logic [IDX_W-1:0] holder_d;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             holding;

    // An ongoing burst overrides the pointer while its holder keeps requesting.
    assign holding = (state_q == ARB_HOLD) && req[holder_q];

    always_comb begin
        sel_gnt   = pick_gnt;
        sel_idx   = pick_idx;
        sel_valid = pick_valid;
        new_grant = pick_valid;
        if (holding) begin
            sel_gnt           = '0;
            sel_gnt[holder_q] = 1'b1;
            sel_idx           = holder_q;
            sel_valid         = 1'b1;
            new_grant         = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        holder_d   = holder_q;
        hold_cnt_d = hold_cnt_q;
        if (en) begin
            if (holding) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_d == CNT_W'(MAX_HOLD)) begin
                    state_d = ARB_IDLE;
                end
            end else if (pick_valid) begin
                holder_d   = pick_idx;
                hold_cnt_d = CNT_W'(1);
                state_d    = (MAX_HOLD > 1) ? ARB_HOLD : ARB_IDLE;
            end else begin
                hold_cnt_d = '0;
                state_d    = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            holder_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            holder_q   <= holder_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    always_comb begin
        sel_gnt   = pick_gnt;
        sel_idx   = pick_idx;
        sel_valid = pick_valid;
        new_grant = pick_valid;
    end
`endif

    // Pointer moves past a fresh winner; a continuing burst leaves it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (en && new_grant) begin
            ptr_d = IDX_W'(rot_next(32'(sel_idx), NUM_REQ));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (!reset && en && sel_valid) begin
            gnt       = sel_gnt;
            gnt_valid = 1'b1;
            gnt_idx   = sel_idx;
        end
    end

    assign ptr = ptr_q;

endmodule
